// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: default word width, the NOP encoding and the fetch packet.
// Later stage queues (ID/EX etc.) reuse the same packet style.
package pipe_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] NOP_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_pkt_t;

  // Index width for an n-entry array; a single entry still needs a 1-bit pointer.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// IF->ID handshake bundle: fetch-side push, decode-side pop, plus occupancy.
// master = fetch/decode stages driving the queue, slave = the queue itself.
interface if_id_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             if_valid;
  logic             if_ready;
  logic [XLEN-1:0]  if_pc_in;
  logic [XLEN-1:0]  if_instr_in;
  logic             id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  id_pc_out;
  logic [XLEN-1:0]  id_instr_out;
  logic [CNT_W-1:0] id_count;

  modport master (
    output if_valid, if_pc_in, if_instr_in, id_ready,
    input  if_ready, id_valid, id_pc_out, id_instr_out, id_count
  );

  modport slave (
    input  if_valid, if_pc_in, if_instr_in, id_ready,
    output if_ready, id_valid, id_pc_out, id_instr_out, id_count
  );

endinterface

// File: rtl/if_id_queue.sv
// Circular DEPTH-entry IF/ID buffer; enqueue visible at ID one edge later, no bypass.
// if_ready = !full from registered count only, so a full queue refuses even when decode pops.
module if_id_queue
  import pipe_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  if_id_queue_if.slave q
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } slot_t;

  slot_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // flush squashes both sides in the same cycle; the handshakes themselves never see it.
  assign enq = q.if_valid & ~full  & ~flush;
  assign deq = q.id_ready & ~empty & ~flush;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= bump(wr_ptr);
      if (deq) rd_ptr <= bump(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr].pc    <= q.if_pc_in;
      mem[wr_ptr].instr <= q.if_instr_in;
    end
  end

  assign q.if_ready     = ~full;
  assign q.id_valid     = ~empty;
  assign q.id_count     = count;
  assign q.id_pc_out    = empty ? '0        : mem[rd_ptr].pc;
  assign q.id_instr_out = empty ? NOP_INSTR : mem[rd_ptr].instr;

endmodule
